// File: rtl/controller_ds2_multi.sv
// DualShock/DualShock2 multi-pad poller.
// Pads share ds_clk, ds_mosi and ds_miso and each has its own chip select.
// Every frame polls each pad with the 9-byte 01 42 00.. command. The reply
// is folded into a 12-bit button word, with optional stick-to-D-pad folding.
module controller_ds2_multi #(
  parameter int FREQ         = 21_600_000,
  parameter int NUM_PADS     = 2,
  parameter int SCK_HZ       = 250_000,
  parameter int POLL_HZ      = 60,
  parameter int STICK_DPAD   = 1,
  parameter int STICK_THRESH = 64
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  output logic                    ds_clk,
  output logic                    ds_mosi,
  input  logic                    ds_miso,
  output logic [NUM_PADS-1:0]     ds_cs,
  output logic [12*NUM_PADS-1:0]  buttons,
  output logic [NUM_PADS-1:0]     present,
  output logic [NUM_PADS-1:0]     analog,
  output logic                    frame_done
);

  localparam int HALF   = FREQ / (2 * SCK_HZ);
  localparam int PERIOD = FREQ / POLL_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW     = $clog2(2 * HALF + 1);
  localparam int LO_LIM = 128 - STICK_THRESH;
  localparam int HI_LIM = 127 + STICK_THRESH;

  typedef enum logic [2:0] {IDLE, SEL, BIT_LO, BIT_HI, GAP, DESEL, NEXT} state_e;

  state_e              state_q;
  logic [PW-1:0]       poll_q;
  logic [TW-1:0]       tmr_q;
  logic [2:0]          bit_q;
  logic [3:0]          byte_q;
  logic [2:0]          pad_q;
  logic                clk_q, mosi_q, fd_q;
  logic [NUM_PADS-1:0] cs_q;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          id_q, ack_q, b0_q, b1_q, lx_q, ly_q;
  logic                tick, half_done, full_done, sample, byte_end, commit;
  logic [11:0]         btn_new;
  logic                pres_new, an_new;

  // Command byte k of the frame is 01, 42, then zeros; bits go out LSB first.
  function automatic logic tx_bit(input logic [3:0] byte_i, input logic [2:0] bit_i);
    logic [7:0] b;
    b = (byte_i == 4'd0) ? 8'h01 : (byte_i == 4'd1) ? 8'h42 : 8'h00;
    return b[bit_i];
  endfunction

  assign tick      = (poll_q == PW'(PERIOD - 1));
  assign half_done = (tmr_q == TW'(HALF - 1));
  assign full_done = (tmr_q == TW'(2 * HALF - 1));
  assign sample    = (state_q == BIT_HI) && (tmr_q == '0);
  assign byte_end  = (state_q == BIT_HI) && half_done && (bit_q == 3'd7);
  assign commit    = (state_q == DESEL) && full_done;

  // Free-running frame-rate counter; the wrap is the poll tick
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) poll_q <= '0;
    else         poll_q <= tick ? '0 : poll_q + 1'b1;
  end

  // Frame sequencer: chip selects, serial clock and command bits, all registered
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      pad_q   <= '0;
      clk_q   <= 1'b1;
      mosi_q  <= 1'b1;
      cs_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      fd_q  <= 1'b0;
      tmr_q <= tmr_q + 1'b1;
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          // A tick arriving while a frame is running is simply lost here.
          if (tick) begin
            pad_q   <= '0;
            cs_q    <= ~NUM_PADS'(1);
            state_q <= SEL;
          end
        end
        SEL: if (full_done) begin
          tmr_q   <= '0;
          byte_q  <= '0;
          bit_q   <= '0;
          clk_q   <= 1'b0;
          mosi_q  <= tx_bit(4'd0, 3'd0);
          state_q <= BIT_LO;
        end
        BIT_LO: if (half_done) begin
          tmr_q   <= '0;
          clk_q   <= 1'b1;
          state_q <= BIT_HI;
        end
        BIT_HI: if (half_done) begin
          tmr_q <= '0;
          if (bit_q != 3'd7) begin
            bit_q   <= bit_q + 3'd1;
            clk_q   <= 1'b0;
            mosi_q  <= tx_bit(byte_q, bit_q + 3'd1);
            state_q <= BIT_LO;
          end else begin
            bit_q  <= '0;
            mosi_q <= 1'b1;
            if (byte_q != 4'd8) begin
              byte_q  <= byte_q + 4'd1;
              state_q <= GAP;
            end else begin
              cs_q    <= '1;
              state_q <= DESEL;
            end
          end
        end
        GAP: if (full_done) begin
          tmr_q   <= '0;
          clk_q   <= 1'b0;
          mosi_q  <= tx_bit(byte_q, 3'd0);
          state_q <= BIT_LO;
        end
        DESEL: if (full_done) begin
          tmr_q   <= '0;
          pad_q   <= pad_q + 3'd1;
          state_q <= NEXT;
        end
        NEXT: begin
          tmr_q <= '0;
          if (pad_q < 3'(NUM_PADS)) begin
            cs_q    <= ~(NUM_PADS'(1) << pad_q);
            state_q <= SEL;
          end else begin
            fd_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next receive byte including this cycle's sample (covers HALF == 1)
  always_comb begin
    rx_d = rx_q;
    if (sample) rx_d = {ds_miso, rx_q[7:1]};
  end

  // Receive shifter plus capture of the reply bytes that matter at commit.
  // ds_miso has been stable for a full half period when it is sampled.
  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    if (byte_end) begin
      case (byte_q)
        4'd1: id_q  <= rx_d;
        4'd2: ack_q <= rx_d;
        4'd3: b0_q  <= rx_d;
        4'd4: b1_q  <= rx_d;
        4'd7: lx_q  <= rx_d;
        4'd8: ly_q  <= rx_d;
        default: ;
      endcase
    end
  end

  // Reply decode: ack/ID classification, active-low buttons, stick folding
  always_comb begin
    pres_new = (ack_q == 8'h5A);
    an_new   = pres_new && (id_q == 8'h73);
    btn_new  = '0;
    if (pres_new) begin
      btn_new = {~b1_q[3] | ~b1_q[1], ~b1_q[2] | ~b1_q[0], ~b1_q[4], ~b1_q[5],
                 ~b0_q[5], ~b0_q[7], ~b0_q[6], ~b0_q[4],
                 ~b0_q[3], ~b0_q[0], ~b1_q[7], ~b1_q[6]};
      if ((STICK_DPAD != 0) && an_new) begin
        if (int'(lx_q) < LO_LIM) btn_new[6] = 1'b1;
        if (int'(lx_q) > HI_LIM) btn_new[7] = 1'b1;
        if (int'(ly_q) < LO_LIM) btn_new[4] = 1'b1;
        if (int'(ly_q) > HI_LIM) btn_new[5] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    logic [11:0] btn_q;
    logic        pres_q, an_q;

    // Pad g's outputs change only when its own reply is committed
    always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
        btn_q  <= '0;
        pres_q <= 1'b0;
        an_q   <= 1'b0;
      end else if (commit && (pad_q == 3'(g))) begin
        btn_q  <= btn_new;
        pres_q <= pres_new;
        an_q   <= an_new;
      end
    end

    assign buttons[12*g +: 12] = btn_q;
    assign present[g]          = pres_q;
    assign analog[g]           = an_q;
  end

  assign ds_clk     = clk_q;
  assign ds_mosi    = mosi_q;
  assign ds_cs      = cs_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_controller_ds2_multi.sv
// Bench for controller_ds2_multi: behavioural pad models on the shared bus,
// two DUT copies (stick folding on / off) running in lockstep.
module tb_controller_ds2_multi;

  localparam int FREQ    = 8000;
  localparam int SCK_HZ  = 1000;
  localparam int POLL_HZ = 8;
  localparam int NP      = 2;
  localparam int TH      = 64;
  localparam int HALF    = FREQ / (2 * SCK_HZ);
  localparam int PERIOD  = FREQ / POLL_HZ;
  localparam logic [71:0] TX_EXP = 72'h00_0000_0000_0000_4201;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic miso = 1'b1;
  logic ds_clk, ds_mosi, fd, ds_clk_b, ds_mosi_b, fd_b;
  logic [NP-1:0] cs, cs_b, pres, pres_b, an, an_b;
  logic [12*NP-1:0] btn, btn_b;

  always #5 clk = ~clk;

  controller_ds2_multi #(.FREQ(FREQ), .NUM_PADS(NP), .SCK_HZ(SCK_HZ), .POLL_HZ(POLL_HZ),
                         .STICK_DPAD(1), .STICK_THRESH(TH)) dut (
    .clk(clk), .I_RSTn(rst_n), .ds_clk(ds_clk), .ds_mosi(ds_mosi), .ds_miso(miso),
    .ds_cs(cs), .buttons(btn), .present(pres), .analog(an), .frame_done(fd));

  controller_ds2_multi #(.FREQ(FREQ), .NUM_PADS(NP), .SCK_HZ(SCK_HZ), .POLL_HZ(POLL_HZ),
                         .STICK_DPAD(0), .STICK_THRESH(TH)) dut_nd (
    .clk(clk), .I_RSTn(rst_n), .ds_clk(ds_clk_b), .ds_mosi(ds_mosi_b), .ds_miso(miso),
    .ds_cs(cs_b), .buttons(btn_b), .present(pres_b), .analog(an_b), .frame_done(fd_b));

  // Pad reply contents, set by the stimulus process between frames
  logic [7:0] p_id [NP], p_ack [NP], p_b0 [NP], p_b1 [NP], p_lx [NP], p_ly [NP];
  logic [71:0] resp [NP];

  // Bus observations recorded by the pad model
  int cyc = 0, lo_bad = 0, hi_bad = 0, cs_multi = 0, lock_bad = 0, cs_falls = 0;
  int bits_rec [NP];
  logic [71:0] tx_rec [NP];

  // Pad model and bus monitor: drives miso on falling ds_clk, captures mosi on rising
  always @(posedge clk) begin : pad_model
    int cur, sel, idx, run;
    logic prev_clk, fall_seen;
    logic [71:0] txcap;
    cyc++;
    if (!rst_n) begin
      cur = -1; run = 0; prev_clk = 1'b1; fall_seen = 1'b0; idx = 0;
      miso <= 1'b1;
    end else begin
      if ($countones(~cs) > 1) cs_multi++;
      if ({ds_clk, ds_mosi, cs, fd, pres, an} !== {ds_clk_b, ds_mosi_b, cs_b, fd_b, pres_b, an_b})
        lock_bad++;
      sel = -1;
      for (int p = 0; p < NP; p++) if (!cs[p]) sel = p;
      if (sel != cur) begin
        if (cur >= 0) begin bits_rec[cur] = idx; tx_rec[cur] = txcap; end
        if (sel >= 0) begin idx = 0; txcap = '0; cs_falls++; fall_seen = 1'b0; end
        cur = sel;
      end
      if (ds_clk == prev_clk) run++;
      else begin
        if (!ds_clk) begin
          if (fall_seen && cur >= 0 && run != HALF && run != 3 * HALF) hi_bad++;
          fall_seen = 1'b1;
          if (cur >= 0 && idx < 72) miso <= resp[cur][idx];
        end else begin
          if (run != HALF) lo_bad++;
          if (cur >= 0 && idx < 72) begin txcap[idx] = ds_mosi; idx++; end
        end
        run = 1;
      end
      prev_clk = ds_clk;
      if (cur < 0) miso <= 1'b1;
    end
  end

  int n_chk = 0, n_fail = 0;
  int prev_fd_cyc, falls_base;
  bit have_prev;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: button word computed directly from the mapping rules
  function automatic logic [11:0] ref_btn(input logic [7:0] id, ack, b0, b1, lx, ly, input bit dp);
    logic [11:0] r;
    r = '0;
    if (ack != 8'h5A) return r;
    r[11] = !b1[3] || !b1[1];  r[10] = !b1[2] || !b1[0];
    r[9]  = !b1[4];  r[8] = !b1[5];  r[7] = !b0[5];  r[6] = !b0[7];
    r[5]  = !b0[6];  r[4] = !b0[4];  r[3] = !b0[3];  r[2] = !b0[0];
    r[1]  = !b1[7];  r[0] = !b1[6];
    if (dp && id == 8'h73) begin
      if (int'(lx) < 128 - TH) r[6] = 1'b1;
      if (int'(lx) > 127 + TH) r[7] = 1'b1;
      if (int'(ly) < 128 - TH) r[4] = 1'b1;
      if (int'(ly) > 127 + TH) r[5] = 1'b1;
    end
    return r;
  endfunction

  task automatic set_pad(input int p, input logic [7:0] id, ack, b0, b1, lx, ly);
    p_id[p] = id; p_ack[p] = ack; p_b0[p] = b0; p_b1[p] = b1; p_lx[p] = lx; p_ly[p] = ly;
    resp[p] = {ly, lx, 8'h00, 8'h00, b1, b0, ack, id, 8'hFF};
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD + 100; i++) begin
      @(negedge clk);
      if (fd) begin ok = 1'b1; break; end
    end
  endtask

  // Everything checked after each frame: timing, bus shape and model outputs
  task automatic frame_checks();
    bit ok;
    int exp_sp;
    wait_frame(ok);
    check("frame_done_seen", 72'(ok), 72'd1);
    exp_sp = PERIOD * ((NP * 164 * HALF + PERIOD - 1) / PERIOD);
    if (have_prev) check("frame_spacing", 72'(cyc - prev_fd_cyc), 72'(exp_sp));
    prev_fd_cyc = cyc; have_prev = 1'b1;
    check("cs_selects_per_frame", 72'(cs_falls - falls_base), 72'(NP));
    falls_base = cs_falls;
    check("bus_shape_errors", 72'(lo_bad + hi_bad + cs_multi + lock_bad), 72'd0);
    for (int p = 0; p < NP; p++) begin
      check("bits_per_pad", 72'(bits_rec[p]), 72'd72);
      check("mosi_bits", tx_rec[p], TX_EXP);
      check("buttons_dpad", 72'(btn[12*p +: 12]),
            72'(ref_btn(p_id[p], p_ack[p], p_b0[p], p_b1[p], p_lx[p], p_ly[p], 1'b1)));
      check("buttons_nodpad", 72'(btn_b[12*p +: 12]),
            72'(ref_btn(p_id[p], p_ack[p], p_b0[p], p_b1[p], p_lx[p], p_ly[p], 1'b0)));
      check("present", 72'(pres[p]), 72'(p_ack[p] == 8'h5A));
      check("analog", 72'(an[p]), 72'(p_ack[p] == 8'h5A && p_id[p] == 8'h73));
    end
  endtask

  typedef struct {
    logic [7:0]  id, ack, b0, b1, lx, ly;
    logic [11:0] e_dp, e_nd;
    logic        e_pres, e_an;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bit ok;
    int bad;
    vecs[0]  = '{8'h41, 8'h5A, 8'hFE, 8'hBF, 8'h80, 8'h80, 12'h005, 12'h005, 1'b1, 1'b0};
    vecs[1]  = '{8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80, 12'h040, 12'h000, 1'b1, 1'b1};
    vecs[2]  = '{8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h40, 8'h80, 12'h000, 12'h000, 1'b1, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 12'h000, 12'h000, 1'b0, 1'b0};
    vecs[4]  = '{8'h73, 8'h5A, 8'hF7, 8'hFF, 8'hC0, 8'h3F, 12'h098, 12'h008, 1'b1, 1'b1};
    vecs[5]  = '{8'h41, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 12'hFFF, 12'hFFF, 1'b1, 1'b0};
    vecs[6]  = '{8'h41, 8'h5A, 8'hFF, 8'hF7, 8'h80, 8'h80, 12'h800, 12'h800, 1'b1, 1'b0};
    vecs[7]  = '{8'h79, 8'h5A, 8'hEF, 8'hFF, 8'h00, 8'h00, 12'h010, 12'h010, 1'b1, 1'b0};
    vecs[8]  = '{8'h73, 8'h5A, 8'hFF, 8'hFE, 8'h80, 8'hC0, 12'h420, 12'h400, 1'b1, 1'b1};
    vecs[9]  = '{8'h73, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 12'h000, 1'b0, 1'b0};
    vecs[10] = '{8'h73, 8'h5A, 8'hFF, 8'hFF, 8'hBF, 8'h41, 12'h000, 12'h000, 1'b1, 1'b1};

    // Asynchronous reset before the first clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_cs", 72'(cs), 72'({NP{1'b1}}));
    check("rst_clk_mosi", 72'({ds_clk, ds_mosi}), 72'b11);
    check("rst_outputs", 72'({btn, pres, an, fd}), 72'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    have_prev = 1'b0;
    falls_base = cs_falls;

    // Table: pad0 digital with START held, pad1 walks the vectors
    for (int i = 0; i < 11; i++) begin
      set_pad(0, 8'h41, 8'h5A, 8'hF7, 8'hFF, 8'h80, 8'h80);
      set_pad(1, vecs[i].id, vecs[i].ack, vecs[i].b0, vecs[i].b1, vecs[i].lx, vecs[i].ly);
      frame_checks();
      check("tbl_pad0", 72'(btn[11:0]), 72'h008);
      check("tbl_pad1_dpad", 72'(btn[23:12]), 72'(vecs[i].e_dp));
      check("tbl_pad1_nodpad", 72'(btn_b[23:12]), 72'(vecs[i].e_nd));
      check("tbl_pad1_flags", 72'({pres[1], an[1]}), 72'({vecs[i].e_pres, vecs[i].e_an}));
    end

    // Random replies on both pads against the reference model
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < NP; p++) begin
        int kind;
        logic [7:0] id, ack;
        kind = $urandom_range(0, 4);
        id  = (kind == 1) ? 8'h41 : (kind == 2) ? 8'h73 : 8'($urandom);
        ack = (kind == 0) ? 8'hFF : (kind == 4) ? 8'($urandom_range(0, 89)) : 8'h5A;
        if (kind == 0) set_pad(p, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        else set_pad(p, id, ack, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      frame_checks();
    end

    // Reset while ds_clk is low inside a frame
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (!ds_clk && cs != '1) begin ok = 1'b1; break; end
    end
    check("found_bit_lo", 72'(ok), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", 72'(cs), 72'({NP{1'b1}}));
    check("midrst_clk_mosi", 72'({ds_clk, ds_mosi}), 72'b11);
    check("midrst_outputs", 72'({btn, btn_b, pres, an}), 72'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < PERIOD / 2; i++) begin
      @(negedge clk);
      if (cs != '1 || fd) bad++;
    end
    check("idle_after_reset", 72'(bad), 72'd0);
    have_prev = 1'b0;
    falls_base = cs_falls;
    set_pad(0, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80);
    set_pad(1, 8'h41, 8'h5A, 8'hFE, 8'hBF, 8'h80, 8'h80);
    frame_checks();
    check("post_reset_pad0", 72'(btn[11:0]), 72'h040);
    check("post_reset_pad1", 72'(btn[23:12]), 72'h005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
